// File: rtl/conv_pkg.sv
// conv_pkg: FP32 constants, commit FSM states and adder-tree sizing
// helpers shared by the tap engine and its sub-modules.
package conv_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SWAP
  } commit_st_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

endpackage

// File: rtl/conv_add_tree.sv
// conv_add_tree: pipelined pairwise FP32 reduction of TAPS operands.
// An odd operand at any level is forwarded to the next level unchanged.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic [TAPS*DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0]      sum_o,
  output logic                       valid_o,
  output logic                       busy_o
);
  localparam int DEPTH = clog2(TAPS);

  logic [DATA_WIDTH-1:0] node   [DEPTH][TAPS];
  logic [DATA_WIDTH-1:0] node_s [DEPTH][TAPS];
  logic [DATA_WIDTH-1:0] lvl_q  [DEPTH][TAPS];
  logic [DEPTH-1:0]      vld_q;
  logic [DEPTH:0]        v_in;

  assign v_in = {vld_q, valid_i};

  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int N = lvl_cnt(TAPS, l);
    for (genvar j = 0; j < TAPS; j++) begin : g_node
      if (l == 0) begin : g_in
        assign node[l][j] = data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_prev
        assign node[l][j] = lvl_q[l-1][j];
      end
      if (2*j + 1 < N) begin : g_add
        Add_Sub u_add (
          .a_i  (node[l][2*j]),
          .b_i  (node[l][2*j+1]),
          .sub_i(1'b0),
          .y_o  (node_s[l][j])
        );
      end else if (2*j < N) begin : g_fwd
        assign node_s[l][j] = node[l][2*j];
      end else begin : g_nil
        assign node_s[l][j] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= v_in[DEPTH-1:0];
    for (int l = 0; l < DEPTH; l++)
      for (int j = 0; j < TAPS; j++)
        if (v_in[l]) lvl_q[l][j] <= node_s[l][j];
  end

  assign sum_o   = lvl_q[DEPTH-1][0];
  assign valid_o = vld_q[DEPTH-1];
  assign busy_o  = |vld_q;

endmodule

// File: rtl/conv_fp.sv
// Combinational FP32 multiply and add/subtract cells.
// Denormals flush to zero, results truncate, NaN is not special-cased.
module Mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic              s;
  logic [47:0]       p;
  logic signed [9:0] e;
  logic [22:0]       m;

  always_comb begin
    s = a_i[31] ^ b_i[31];
    p = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    e = 10'(a_i[30:23]) + 10'(b_i[30:23]) - 10'd127 + 10'(p[47]);
    m = p[47] ? p[46:24] : p[45:23];
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0 || e <= 10'sd0)
      y_o = {s, 31'd0};
    else if (e >= 10'sd255)
      y_o = {s, 8'hFF, 23'd0};
    else
      y_o = {s, e[7:0], m};
  end
endmodule

module Add_Sub (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] y_o
);
  logic              sb, sx, sy, swp, hit;
  logic [7:0]        ex, ey, d;
  logic [26:0]       mx, my, ys, nrm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] e;

  always_comb begin
    sb  = b_i[31] ^ sub_i;
    swp = b_i[30:0] > a_i[30:0];
    sx  = swp ? sb : a_i[31];
    sy  = swp ? a_i[31] : sb;
    ex  = swp ? b_i[30:23] : a_i[30:23];
    ey  = swp ? a_i[30:23] : b_i[30:23];
    mx  = (ex == 8'd0) ? 27'd0
        : {1'b1, (swp ? b_i[22:0] : a_i[22:0]), 3'b000};
    my  = (ey == 8'd0) ? 27'd0
        : {1'b1, (swp ? a_i[22:0] : b_i[22:0]), 3'b000};
    d   = ex - ey;
    ys  = (d > 8'd26) ? 27'd0 : my >> d;
    sum = (sx == sy) ? {1'b0, mx} + {1'b0, ys}
                     : {1'b0, mx} - {1'b0, ys};
    lz  = 5'd0;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && sum[i]) begin
        lz  = 5'(26 - i);
        hit = 1'b1;
      end
    end
    e = 10'(ex);
    if (sum[27]) begin
      nrm = sum[27:1];
      e   = e + 10'sd1;
    end else begin
      nrm = sum[26:0] << lz;
      e   = e - 10'(lz);
    end
    if (sum == 28'd0 || e <= 10'sd0)
      y_o = 32'd0;
    else if (e >= 10'sd255)
      y_o = {sx, 8'hFF, 23'd0};
    else
      y_o = {sx, e[7:0], nrm[25:3]};
  end
endmodule

// File: rtl/conv_tap_engine.sv
// conv_tap_engine: FP32 convolution tap engine with double-buffered weights.
// The shadow bank is copied to the active bank only once the pipe is empty.
module conv_tap_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS       = 9,
  parameter int IDX_W      = $clog2(TAPS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TAPS*DATA_WIDTH-1:0] i_data,
  input  logic                       valid_in,
  output logic                       in_ready,
  input  logic                       w_we,
  input  logic [IDX_W-1:0]           w_idx,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic                       w_commit,
  input  logic                       relu_en,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       valid_out,
  output logic                       busy
);
  commit_st_e state_q, state_d;
  logic       swap, accept;

  logic [DATA_WIDTH-1:0]      shadow_q [TAPS+1];
  logic [DATA_WIDTH-1:0]      active_q [TAPS+1];
  logic [TAPS*DATA_WIDTH-1:0] win_q, prod_d, prod_q;
  logic                       win_v_q, prod_v_q, out_v_q;
  logic                       tree_v, tree_busy;
  logic [DATA_WIDTH-1:0]      tree_sum, biased, out_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    swap     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        in_ready = 1'b1;
        if (w_commit) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (!busy) state_d = ST_SWAP;
      ST_SWAP: begin
        swap    = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign accept = valid_in && in_ready;

  // Active bank takes the pre-write shadow on a SWAP-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      for (int t = 0; t <= TAPS; t++) begin
        shadow_q[t] <= '0;
        active_q[t] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (w_we && 32'(w_idx) <= TAPS) shadow_q[w_idx] <= w_data;
      if (swap) active_q <= shadow_q;
    end
  end

  for (genvar t = 0; t < TAPS; t++) begin : g_mul
    Mul u_mul (
      .a_i(win_q[t*DATA_WIDTH +: DATA_WIDTH]),
      .b_i(active_q[t]),
      .y_o(prod_d[t*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  conv_add_tree #(
    .DATA_WIDTH(DATA_WIDTH),
    .TAPS      (TAPS)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .valid_i(prod_v_q),
    .data_i (prod_q),
    .sum_o  (tree_sum),
    .valid_o(tree_v),
    .busy_o (tree_busy)
  );

  Add_Sub u_bias (
    .a_i  (tree_sum),
    .b_i  (active_q[TAPS]),
    .sub_i(1'b0),
    .y_o  (biased)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      win_v_q  <= 1'b0;
      prod_v_q <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      win_v_q  <= accept;
      prod_v_q <= win_v_q;
      out_v_q  <= tree_v;
      if (tree_v)
        out_q <= (relu_en && biased[DATA_WIDTH-1]) ? FP_ZERO : biased;
    end
    if (accept)  win_q  <= i_data;
    if (win_v_q) prod_q <= prod_d;
  end

  assign busy      = win_v_q | prod_v_q | tree_busy | out_v_q;
  assign o_data    = out_q;
  assign valid_out = out_v_q;

endmodule

// File: tb/tb_conv_tap_engine.sv
// tb_conv_tap_engine: scoreboard bench for the FP32 tap engine.
// Directed windows push expected results; monitors pop on valid_out.
`timescale 1ns/1ps
module tb_conv_tap_engine;
  import conv_pkg::*;

  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] NEG1  = 32'hBF80_0000;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [287:0]  i_data;
  logic          valid_in, in_ready, w_we, w_commit, relu_en;
  logic [3:0]    w_idx;
  logic [31:0]   w_data, o_data;
  logic          valid_out, busy;

  logic [799:0]  d25;
  logic          v25, rdy25, we25, cm25, vo25, busy25;
  logic [4:0]    idx25;
  logic [31:0]   wd25, o25;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   max_run = 0;
  sb_t  sbq[$];
  sb_t  q25[$];

  conv_tap_engine #(.DATA_WIDTH(32), .TAPS(9)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in),
    .in_ready(in_ready), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .w_commit(w_commit), .relu_en(relu_en), .o_data(o_data),
    .valid_out(valid_out), .busy(busy)
  );

  conv_tap_engine #(.DATA_WIDTH(32), .TAPS(25)) dut25 (
    .clk(clk), .rst(rst), .i_data(d25), .valid_in(v25),
    .in_ready(rdy25), .w_we(we25), .w_idx(idx25), .w_data(wd25),
    .w_commit(cm25), .relu_en(1'b0), .o_data(o25),
    .valid_out(vo25), .busy(busy25)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin : mon9
    sb_t e;
    if (valid_out) begin
      run++;
      if (run > max_run) max_run = run;
      if (sbq.size() == 0) chk("spurious_valid_out", 32'(valid_out), 32'd0);
      else begin
        e = sbq.pop_front();
        chk("o_data", o_data, e.exp);
        chk("latency9", 32'(cyc - e.acc), 32'd6);
      end
    end else run = 0;
  end

  always @(negedge clk) begin : mon25
    sb_t e;
    if (vo25) begin
      if (q25.size() == 0) chk("spurious_vo25", 32'(vo25), 32'd0);
      else begin
        e = q25.pop_front();
        chk("o_data25", o25, e.exp);
        chk("latency25", 32'(cyc - e.acc), 32'd7);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    valid_in = 1'b0;
    w_we     = 1'b0;
    w_commit = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    step();
    w_we   = 1'b1;
    w_idx  = 4'(idx);
    w_data = d;
  endtask

  task automatic set_w(input logic [31:0] w, input logic [31:0] b);
    for (int t = 0; t < 9; t++) wr(t, w);
    wr(9, b);
  endtask

  task automatic commit();
    step();
    w_commit = 1'b1;
  endtask

  task automatic send(input logic [31:0] px, input logic [31:0] exp);
    int  n;
    sb_t e;
    step();
    valid_in = 1'b1;
    i_data   = {9{px}};
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    else begin
      e.exp = exp;
      e.acc = cyc + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    step();
    while ((busy || sbq.size() != 0 || !in_ready) && n < 100) begin
      step();
      n++;
    end
    chk("drain_sb", 32'(sbq.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    sb_t e;
    int  n;
    rst = 1'b1; valid_in = 1'b0; w_we = 1'b0; w_commit = 1'b0;
    relu_en = 1'b0; i_data = '0; w_idx = '0; w_data = '0;
    d25 = '0; v25 = 1'b0; we25 = 1'b0; cm25 = 1'b0;
    idx25 = '0; wd25 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // 2.0 weights, zero bias, plus an ignored out-of-range write
    set_w(TWO, FP_ZERO);
    wr(10, FP_ONE);
    wr(15, THREE);
    commit();
    send(FP_ONE, 32'h4190_0000);
    drain();

    wr(9, FP_ONE);
    commit();
    send(FP_ONE, 32'h4198_0000);
    drain();
    max_run = 0;
    for (int i = 0; i < 20; i++) send(FP_ONE, 32'h4198_0000);
    drain();
    chk("burst_pulses", 32'(max_run), 32'd20);

    set_w(NEG1, FP_ZERO);
    commit();
    send(FP_ONE, 32'hC110_0000);
    drain();
    relu_en = 1'b1;
    send(FP_ONE, 32'h0000_0000);
    drain();

    // positive results pass through ReLU untouched
    set_w(TWO, FP_ZERO);
    commit();
    send(FP_ONE, 32'h4190_0000);
    drain();
    set_w(THREE, FP_ZERO);
    for (int i = 0; i < 5; i++) send(FP_ONE, 32'h4190_0000);
    commit();
    step();
    chk("ready_drop", 32'(in_ready), 32'd0);
    send(FP_ONE, 32'h41D8_0000);
    drain();
    relu_en = 1'b0;

    // bias write landing in the SWAP cycle reaches shadow only
    commit();
    step();
    wr(9, FP_ONE);
    send(FP_ONE, 32'h41D8_0000);
    drain();
    commit();
    send(FP_ONE, 32'h41E0_0000);
    drain();

    for (int i = 0; i < 5; i++) send(FP_ONE, 32'h41E0_0000);
    step();
    step();
    wr(0, TWO);
    w_commit = 1'b1;
    rst = 1'b1;
    #1 sbq.delete();
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_o_data", o_data, 32'd0);
    rst = 1'b0;
    repeat (12) step();
    send(FP_ONE, 32'h0000_0000);
    drain();
    commit();
    send(FP_ONE, 32'h0000_0000);
    drain();

    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      we25 = 1'b1; idx25 = 5'(t); wd25 = FP_ONE;
    end
    @(negedge clk);
    we25 = 1'b0; cm25 = 1'b1;
    @(negedge clk);
    cm25 = 1'b0;
    n = 0;
    while (!rdy25 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready25", 32'(rdy25), 32'd1);
    v25 = 1'b1;
    d25 = {25{FP_ONE}};
    e.exp = 32'h41C8_0000;
    e.acc = cyc + 1;
    q25.push_back(e);
    @(negedge clk);
    v25 = 1'b0;
    n = 0;
    while (q25.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("q25_drained", 32'(q25.size()), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
